itch_feed_scheduler: RTL and testbench
======================================

Name: itch_feed_scheduler

Overview:
Message-granular round-robin arbiter that shares the single ITCH parser byte input between two feed channels, A and B.
- Each channel delivers length-prefixed frames: a 2-byte big-endian length L, then L message bytes.
- The block strips the prefix and forwards payload bytes to the parser's byte_in/valid_in.
- It enforces idle gaps between messages, so parser decoders see clean message boundaries.
- It drops illegal-length frames and keeps per-channel message counters.

Parameters:
MAX_LEN, 50, largest legal payload length in bytes; L > MAX_LEN is an error.
MIN_GAP, 1, idle cycles forced on byte_out after each forwarded or dropped message (0 allowed).
CNT_W, 32, width of message counters.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
a_byte  in  8  channel A frame byte
a_valid  in  1  channel A byte valid
a_ready  out  1  channel A byte accepted this cycle when a_valid & a_ready
b_byte  in  8  channel B frame byte
b_valid  in  1  channel B byte valid
b_ready  out  1  channel B byte accepted this cycle when b_valid & b_ready
byte_out  out  8  payload byte to parser byte_in
valid_out  out  1  to parser valid_in
msg_start  out  1  pulse with first payload byte
msg_end  out  1  pulse with last payload byte
msg_src  out  1  source of current/last message (0=A, 1=B)
err_len  out  1  one-cycle pulse: frame dropped (L==0 or L>MAX_LEN)
msg_count_a  out  CNT_W  messages forwarded from A
msg_count_b  out  CNT_W  messages forwarded from B
drop_count  out  16  frames dropped, both channels

Behaviour:
- **Reset (rst low, async):**
  - state=IDLE, rr_ptr=0 (A favoured next), grant=0.
  - All outputs 0, including a_ready/b_ready, counters, byte_out and pulses.
  - Reset mid-message abandons the frame; on release the scheduler restarts in IDLE. Upstream is responsible for resync.
- **States:** IDLE, LEN_HI, LEN_LO, PAYLOAD, DROP, GAP.
- **IDLE:**
  - No ready asserted.
  - If exactly one channel is valid, grant it.
  - If both are valid, grant the channel selected by rr_ptr.
  - Go to LEN_HI. The IDLE cycle consumes no byte.
- **Ready:** ready of the granted channel = 1 in LEN_HI, LEN_LO, PAYLOAD, DROP. It is 0 otherwise. The non-granted channel's ready is always 0.
- **Transfer:** xfer = granted valid & ready. States advance only on xfer; without xfer the state holds indefinitely (no timeout).
- **LEN_HI:** on xfer, len[15:8] = byte; go to LEN_LO.
- **LEN_LO:**
  - On xfer, len[7:0] = byte.
  - If full L == 0 or L > MAX_LEN: pulse err_len next cycle, drop_count += 1 (saturating at 0xFFFF).
    - L == 0 goes to GAP.
    - L > MAX_LEN goes to DROP with remaining = L.
  - Otherwise remaining = L; go to PAYLOAD.
- **PAYLOAD:**
  - Each xfer: next cycle valid_out=1 and byte_out=byte. Latency is 1 cycle, registered.
  - remaining decrements on each xfer.
  - msg_start is asserted with the first payload byte; msg_end with the byte where remaining hits 0. For L=1 both are asserted together.
  - msg_src is registered at grant time and holds until the next grant.
  - After the last xfer: increment msg_count_a or msg_count_b (wrapping), set rr_ptr = ~grant, go to GAP.
- **DROP:**
  - Consume L bytes with valid_out=0.
  - At the end, set rr_ptr = ~grant and go to GAP.
- **Idle bytes out:** valid_out=0 whenever no xfer occurred in PAYLOAD the previous cycle. Gaps in upstream valid mid-message produce valid_out bubbles, not message termination.
- **GAP:**
  - Counts MIN_GAP cycles with valid_out=0, then goes to IDLE.
  - If MIN_GAP=0, the PAYLOAD/DROP/LEN_LO exits go directly to IDLE.
- **Fairness:** with both channels continuously valid, messages strictly alternate A,B,A,... First after reset is A.
- **Width:** remaining is 16 bits; L up to 65535 is handled in DROP.

Test Plan:
1. **Single frame from A:** A sends 00 03 41 11 22, B idle. Expect:
   - valid_out on 3 consecutive cycles with bytes 41,11,22.
   - msg_start with 41, msg_end with 22, msg_src=0.
   - msg_count_a=1, then ≥1 idle cycle.
2. **Simultaneous contention:** A and B each hold two back-to-back 4-byte frames valid from reset. Expect:
   - Output order A1,B1,A2,B2.
   - Each message is contiguous with no interleaving.
   - Counts are 2 and 2.
   - Non-granted ready stays 0 throughout.
3. **Illegal lengths:** B sends 00 00, then 00 40 followed by 64 bytes, then 00 01 53. Expect:
   - Two err_len pulses, drop_count=2.
   - No valid_out for the dropped bytes.
   - Then one-byte message 53 with msg_start=msg_end=1, msg_count_b=1.
4. **Upstream stall:** A sends 00 02 AA, deasserts valid 5 cycles, then sends BB. Expect:
   - AA, 5 bubble cycles, then BB with msg_end.
   - B frame arriving during the stall is not granted until A completes.
5. **Async reset mid-PAYLOAD:** reset asserted after 2 of 5 bytes. Expect:
   - All outputs 0 immediately, without waiting for clk.
   - After release, a fresh A frame 00 01 7F yields a single 7F with msg_start/msg_end, msg_count_a=1.
6. **MIN_GAP=3 instance:** two A frames back-to-back. Expect exactly 3 cycles of valid_out=0 after msg_end, plus 3 more cycles (IDLE, LEN_HI, LEN_LO) before the next msg_start.

Source files
------------

// File: rtl/itch_feed_scheduler.sv
// Round-robin, message-granular mux of two length-prefixed byte feeds onto one parser input.
// Payload appears one cycle after acceptance; a channel is held off (ready=0) until it owns a whole frame.
module itch_feed_scheduler #(
    parameter int MAX_LEN = 50,
    parameter int MIN_GAP = 1,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       a_byte,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [7:0]       b_byte,
    input  logic             b_valid,
    output logic             b_ready,
    output logic [7:0]       byte_out,
    output logic             valid_out,
    output logic             msg_start,
    output logic             msg_end,
    output logic             msg_src,
    output logic             err_len,
    output logic [CNT_W-1:0] msg_count_a,
    output logic [CNT_W-1:0] msg_count_b,
    output logic [15:0]      drop_count
);

    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, PAYLOAD, DROP, GAP} state_t;

    localparam logic [15:0] MAX_L    = 16'(MAX_LEN);
    localparam logic [15:0] GAP_LAST = 16'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);
    localparam state_t      DONE_ST  = (MIN_GAP == 0) ? IDLE : GAP;

    state_t      state, state_nxt;
    logic        grant, rr_ptr, pick;
    logic        busy, in_vld, xfer, last, len_bad, first;
    logic [7:0]  in_byte, len_hi;
    logic [15:0] frame_len, remaining, gap_cnt;

    assign busy      = (state == LEN_HI) || (state == LEN_LO) ||
                       (state == PAYLOAD) || (state == DROP);
    assign a_ready   = busy & ~grant;
    assign b_ready   = busy & grant;
    assign in_vld    = grant ? b_valid : a_valid;
    assign in_byte   = grant ? b_byte : a_byte;
    assign xfer      = busy & in_vld;
    assign last      = xfer && (remaining == 16'd1);
    assign frame_len = {len_hi, in_byte};
    assign len_bad   = (frame_len == 16'd0) || (frame_len > MAX_L);
    assign msg_src   = grant;

    // Contention goes to rr_ptr; a lone requester always wins.
    assign pick = a_valid ? (b_valid ? rr_ptr : 1'b0) : 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (a_valid || b_valid) state_nxt = LEN_HI;
            LEN_HI:  if (xfer) state_nxt = LEN_LO;
            LEN_LO: begin
                if (xfer) begin
                    if (frame_len == 16'd0)  state_nxt = DONE_ST;
                    else if (frame_len > MAX_L) state_nxt = DROP;
                    else                     state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: if (last) state_nxt = DONE_ST;
            DROP:    if (last) state_nxt = DONE_ST;
            GAP:     if (gap_cnt == GAP_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant       <= 1'b0;
            rr_ptr      <= 1'b0;
            len_hi      <= 8'h00;
            remaining   <= 16'd0;
            first       <= 1'b0;
            gap_cnt     <= 16'd0;
            byte_out    <= 8'h00;
            valid_out   <= 1'b0;
            msg_start   <= 1'b0;
            msg_end     <= 1'b0;
            err_len     <= 1'b0;
            msg_count_a <= '0;
            msg_count_b <= '0;
            drop_count  <= 16'd0;
        end else begin
            byte_out  <= 8'h00;
            valid_out <= 1'b0;
            msg_start <= 1'b0;
            msg_end   <= 1'b0;
            err_len   <= 1'b0;
            gap_cnt   <= (state == GAP) ? gap_cnt + 16'd1 : 16'd0;
            case (state)
                IDLE: if (a_valid || b_valid) grant <= pick;
                LEN_HI: if (xfer) len_hi <= in_byte;
                LEN_LO: begin
                    if (xfer) begin
                        remaining <= frame_len;
                        first     <= 1'b1;
                        if (len_bad) begin
                            err_len <= 1'b1;
                            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (xfer) begin
                        valid_out <= 1'b1;
                        byte_out  <= in_byte;
                        msg_start <= first;
                        msg_end   <= last;
                        first     <= 1'b0;
                        remaining <= remaining - 16'd1;
                        if (last) begin
                            rr_ptr <= ~grant;
                            if (grant) msg_count_b <= msg_count_b + CNT_W'(1);
                            else       msg_count_a <= msg_count_a + CNT_W'(1);
                        end
                    end
                end
                DROP: begin
                    if (xfer) remaining <= remaining - 16'd1;
                    if (last) rr_ptr <= ~grant;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_itch_feed_scheduler.sv
// Bench for itch_feed_scheduler: queued byte drivers, scoreboard of expected payload beats.
module tb_itch_feed_scheduler;

    typedef struct {
        logic [7:0] b;
        bit         s;
        bit         e;
        bit         sr;
        int         run;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        vld[3];
    logic [7:0]  dat[3];
    logic        rdy[4];
    logic [7:0]  bo[2];
    logic        vo[2], ms[2], me[2], src[2], el[2];
    logic [31:0] ca[2], cb[2];
    logic [15:0] dc[2];

    logic [8:0]  dq[3][$];
    exp_t        exp_q[2][$];
    int          flush_gen;
    int          nout[2];
    int          errs[2];
    int          bad_rdy[2];
    int          checks, passes;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    itch_feed_scheduler u_dut (
        .clk(clk), .rst(rst),
        .a_byte(dat[0]), .a_valid(vld[0]), .a_ready(rdy[0]),
        .b_byte(dat[1]), .b_valid(vld[1]), .b_ready(rdy[1]),
        .byte_out(bo[0]), .valid_out(vo[0]), .msg_start(ms[0]), .msg_end(me[0]),
        .msg_src(src[0]), .err_len(el[0]),
        .msg_count_a(ca[0]), .msg_count_b(cb[0]), .drop_count(dc[0])
    );

    itch_feed_scheduler #(.MIN_GAP(3)) u_gap3 (
        .clk(clk), .rst(rst),
        .a_byte(dat[2]), .a_valid(vld[2]), .a_ready(rdy[2]),
        .b_byte(8'h00), .b_valid(1'b0), .b_ready(rdy[3]),
        .byte_out(bo[1]), .valid_out(vo[1]), .msg_start(ms[1]), .msg_end(me[1]),
        .msg_src(src[1]), .err_len(el[1]),
        .msg_count_a(ca[1]), .msg_count_b(cb[1]), .drop_count(dc[1])
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %0h required %0h", nm, got, want);
    endtask

    task automatic put(input int ch, input int v);
        dq[ch].push_back(9'(v));
    endtask

    task automatic stall(input int ch, input int n);
        for (int i = 0; i < n; i++) dq[ch].push_back(9'h100);
    endtask

    task automatic exp_b(input int u, input int b, input bit s, input bit e, input bit sr, input int run);
        exp_t x;
        x.b = 8'(b); x.s = s; x.e = e; x.sr = sr; x.run = run;
        exp_q[u].push_back(x);
    endtask

    task automatic frame4(input int ch, input int u, input bit sr, input int base, input int run0);
        put(ch, 0); put(ch, 4);
        for (int i = 0; i < 4; i++) begin
            put(ch, base + i);
            exp_b(u, base + i, i == 0, i == 3, sr, (i == 0) ? run0 : 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        flush_gen++;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_drain(input int u);
        for (int i = 0; i < 500; i++) begin
            if (exp_q[u].size() == 0) break;
            @(negedge clk);
        end
        chk("drain", 64'(exp_q[u].size()), 64'(0));
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_out(input int u, input int n);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (nout[u] >= n) break;
        end
        chk("wait_out", 64'(nout[u] >= n), 64'(1));
    endtask

    // Byte drivers: one beat per queue entry, held until accepted; bit 8 marks an idle cycle.
    initial begin
        int         seen;
        logic [8:0] e;
        bit         will[3];
        seen = 0;
        for (int c = 0; c < 3; c++) begin vld[c] = 1'b0; dat[c] = 8'h00; will[c] = 1'b0; end
        forever begin
            @(negedge clk);
            if (seen != flush_gen) begin
                seen = flush_gen;
                for (int c = 0; c < 3; c++) begin dq[c].delete(); vld[c] = 1'b0; will[c] = 1'b0; end
            end
            for (int c = 0; c < 3; c++) begin
                if (!vld[c] || will[c]) begin
                    if (dq[c].size() > 0) begin
                        e = dq[c].pop_front();
                        vld[c] = !e[8];
                        dat[c] = e[7:0];
                    end else begin
                        vld[c] = 1'b0;
                    end
                end
            end
            #1;
            for (int c = 0; c < 3; c++) will[c] = vld[c] && rdy[c];
        end
    end

    // Output monitor: pops the scoreboard on every valid beat, tracks idle runs and pulses.
    initial begin
        int   run[2];
        exp_t x;
        for (int u = 0; u < 2; u++) begin run[u] = -1; nout[u] = 0; errs[u] = 0; bad_rdy[u] = 0; end
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                if (!rst) begin
                    run[u] = -1; errs[u] = 0; bad_rdy[u] = 0;
                end else begin
                    if (el[u]) errs[u]++;
                    if ((rdy[2*u] && src[u]) || (rdy[2*u+1] && !src[u])) bad_rdy[u]++;
                    if (vo[u]) begin
                        nout[u]++;
                        if (exp_q[u].size() == 0) begin
                            checks++;
                            $display("FAIL unexpected_out: got byte %0h on unit %0d, required no output", bo[u], u);
                        end else begin
                            x = exp_q[u].pop_front();
                            chk("out_byte", 64'(bo[u]), 64'(x.b));
                            chk("out_start_end_src", 64'({ms[u], me[u], src[u]}), 64'({x.s, x.e, x.sr}));
                            if (x.run >= 0) chk("idle_run", 64'(run[u]), 64'(x.run));
                        end
                        run[u] = 0;
                    end else if (run[u] >= 0) begin
                        run[u]++;
                    end
                end
            end
        end
    end

    initial begin
        int base;
        rst = 1'b0; flush_gen = 0; checks = 0; passes = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_u0", 64'({rdy[0], rdy[1], bo[0], vo[0], ms[0], me[0], src[0], el[0]}), 64'(0));
        chk("rst_cnt_u0", 64'({ca[0], cb[0]}), 64'(0));
        chk("rst_drop_u0", 64'(dc[0]), 64'(0));
        @(negedge clk);
        rst = 1'b1;

        // Single frame from A
        put(0, 0); put(0, 3); put(0, 'h41); put(0, 'h11); put(0, 'h22);
        exp_b(0, 'h41, 1, 0, 0, -1); exp_b(0, 'h11, 0, 0, 0, 0); exp_b(0, 'h22, 0, 1, 0, 0);
        wait_drain(0);
        chk("t1_counts", 64'({ca[0], cb[0]}), {32'd1, 32'd0});

        // Contention from reset: strict A,B,A,B alternation
        do_reset();
        frame4(0, 0, 0, 'h10, -1);
        frame4(1, 0, 1, 'h20, 4);
        frame4(0, 0, 0, 'h14, 4);
        frame4(1, 0, 1, 'h24, 4);
        rst = 1'b1;
        wait_drain(0);
        chk("t2_counts", 64'({ca[0], cb[0]}), {32'd2, 32'd2});
        chk("t2_foreign_ready", 64'(bad_rdy[0]), 64'(0));

        // Illegal lengths on B: zero-length, oversize (64), then a legal one-byte frame
        do_reset();
        put(1, 0); put(1, 0);
        put(1, 0); put(1, 'h40);
        for (int i = 0; i < 64; i++) put(1, i);
        put(1, 0); put(1, 1); put(1, 'h53);
        exp_b(0, 'h53, 1, 1, 1, -1);
        rst = 1'b1;
        wait_drain(0);
        chk("t3_err_pulses", 64'(errs[0]), 64'(2));
        chk("t3_drop_count", 64'(dc[0]), 64'(2));
        chk("t3_counts", 64'({ca[0], cb[0]}), {32'd0, 32'd1});

        // Upstream stall on A; B frame arrives mid-stall and must wait
        do_reset();
        put(0, 0); put(0, 2); put(0, 'hAA); stall(0, 5); put(0, 'hBB);
        exp_b(0, 'hAA, 1, 0, 0, -1); exp_b(0, 'hBB, 0, 1, 0, 5); exp_b(0, 'hCC, 1, 1, 1, 4);
        base = nout[0];
        rst = 1'b1;
        wait_out(0, base + 1);
        put(1, 0); put(1, 1); put(1, 'hCC);
        wait_drain(0);
        chk("t4_counts", 64'({ca[0], cb[0]}), {32'd1, 32'd1});

        // Async reset after two of five payload bytes
        put(0, 0); put(0, 5); put(0, 'h11); put(0, 'h22); put(0, 'h33); put(0, 'h44); put(0, 'h55);
        exp_b(0, 'h11, 1, 0, 0, -1); exp_b(0, 'h22, 0, 0, 0, 0);
        base = nout[0];
        wait_out(0, base + 2);
        rst = 1'b0;
        #1;
        chk("t5_async_out", 64'({rdy[0], rdy[1], bo[0], vo[0], ms[0], me[0], src[0], el[0]}), 64'(0));
        chk("t5_async_cnt", 64'({ca[0], cb[0]}), 64'(0));
        flush_gen++;
        repeat (3) @(negedge clk);
        chk("t5_no_leftover", 64'(exp_q[0].size()), 64'(0));
        put(0, 0); put(0, 1); put(0, 'h7F);
        exp_b(0, 'h7F, 1, 1, 0, -1);
        rst = 1'b1;
        wait_drain(0);
        chk("t5_counts", 64'({ca[0], cb[0]}), {32'd1, 32'd0});

        // MIN_GAP=3: 3 gap cycles plus IDLE/LEN_HI/LEN_LO between messages
        do_reset();
        put(2, 0); put(2, 2); put(2, 'h31); put(2, 'h32);
        put(2, 0); put(2, 2); put(2, 'h33); put(2, 'h34);
        exp_b(1, 'h31, 1, 0, 0, -1); exp_b(1, 'h32, 0, 1, 0, 0);
        exp_b(1, 'h33, 1, 0, 0, 6);  exp_b(1, 'h34, 0, 1, 0, 0);
        rst = 1'b1;
        wait_drain(1);
        chk("t6_count_a", 64'(ca[1]), 64'(2));
        chk("t6_foreign_ready", 64'(bad_rdy[1]), 64'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
